// File: rtl/secure_mem_ctrl_if.sv
// Request/response bus of secure_mem_ctrl: one request per cycle in, one registered response out.
interface secure_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_rom;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_rom, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_rom, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/secure_mem_ctrl.sv
// Key-gated RAM/ROM-region controller with bad-key lockout.
// Optional idle-session timeout is compiled in by defining SECURE_MEM_TIMEOUT_EN.
module secure_mem_ctrl #(
    parameter int              DATA_W      = 8,
    parameter int              ADDR_W      = 4,
    parameter int              KEY_W       = 8,
    parameter logic [KEY_W-1:0] RAM_KEY    = 8'hBF,
    parameter logic [KEY_W-1:0] ROM_KEY    = 8'h3E,
    parameter int              MAX_FAILS   = 3,
    parameter int              LOCK_CYCLES = 16,
    parameter int              TIMEOUT     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    input  logic             lock_req,
    secure_mem_ctrl_if.slave bus,
    output logic             sess_ram,
    output logic             sess_rom,
    output logic             locked_out
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FW    = $clog2(MAX_FAILS + 1);
    localparam int LW    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SESS_RAM, SESS_ROM, LOCKOUT} state_t;

    state_t          state, state_nxt;
    logic [FW-1:0]   fail_cnt, fail_nxt;
    logic [LW-1:0]   lock_cnt, lock_nxt;
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] rom_mem [DEPTH];
    logic              rsp_vld_p1, rsp_err_p1;
    logic [DATA_W-1:0] rsp_data_p1;
    logic              accept, permit;

`ifdef SECURE_MEM_TIMEOUT_EN
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    logic [IW-1:0] idle_cnt, idle_nxt;
`endif

    // Permission is judged on the registered state, i.e. before any same-cycle key/lock event.
    function automatic logic allowed(state_t s, logic we, logic rom);
        if (rom)
            return !we || (s == SESS_ROM);
        return s == SESS_RAM;
    endfunction

    assign accept = bus.req_valid && bus.req_ready;
    assign permit = allowed(state, bus.req_we, bus.req_rom);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fail_cnt <= '0;
            lock_cnt <= '0;
`ifdef SECURE_MEM_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
            lock_cnt <= lock_nxt;
`ifdef SECURE_MEM_TIMEOUT_EN
            idle_cnt <= idle_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        lock_nxt  = lock_cnt;
`ifdef SECURE_MEM_TIMEOUT_EN
        idle_nxt  = idle_cnt;
`endif
        if (state == LOCKOUT) begin
            if (lock_cnt == LOCK_LAST) begin
                state_nxt = IDLE;
                fail_nxt  = '0;
                lock_nxt  = '0;
            end else begin
                lock_nxt = lock_cnt + 1'b1;
            end
        end else begin
`ifdef SECURE_MEM_TIMEOUT_EN
            if (state != IDLE) begin
                if (accept)
                    idle_nxt = '0;
                else if (idle_cnt == IDLE_LAST) begin
                    state_nxt = IDLE;
                    idle_nxt  = '0;
                end else
                    idle_nxt = idle_cnt + 1'b1;
            end
`endif
            // lock_req outranks a key presented in the same cycle.
            if (lock_req) begin
                state_nxt = IDLE;
            end else if (key_valid) begin
                if (key_in == RAM_KEY || key_in == ROM_KEY) begin
                    state_nxt = (key_in == RAM_KEY) ? SESS_RAM : SESS_ROM;
                    fail_nxt  = '0;
`ifdef SECURE_MEM_TIMEOUT_EN
                    idle_nxt  = '0;
`endif
                end else begin
                    state_nxt = (fail_cnt == FAIL_LAST) ? LOCKOUT : IDLE;
                    fail_nxt  = fail_cnt + 1'b1;
                    lock_nxt  = '0;
                end
            end
        end
    end

    always_comb begin
        sess_ram      = (state == SESS_RAM);
        sess_rom      = (state == SESS_ROM);
        locked_out    = (state == LOCKOUT);
        bus.req_ready = (state != LOCKOUT);
    end

    // Memory arrays carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && permit && bus.req_we) begin
            if (bus.req_rom)
                rom_mem[bus.req_addr] <= bus.req_wdata;
            else
                ram_mem[bus.req_addr] <= bus.req_wdata;
        end
    end

    // Response stage: reads see memory as of the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_p1  <= 1'b0;
            rsp_err_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            rsp_vld_p1 <= accept;
            rsp_err_p1 <= accept && !permit;
            if (accept && permit && !bus.req_we)
                rsp_data_p1 <= bus.req_rom ? rom_mem[bus.req_addr] : ram_mem[bus.req_addr];
            else
                rsp_data_p1 <= '0;
        end
    end

    assign bus.rsp_valid = rsp_vld_p1;
    assign bus.rsp_err   = rsp_err_p1;
    assign bus.rsp_data  = rsp_data_p1;
endmodule

// File: tb/tb_secure_mem_ctrl.sv
// Directed bench for secure_mem_ctrl: sessions, permissions, lockout, reset abort, optional timeout.
module tb_secure_mem_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_in;
    logic       lock_req;
    logic       sess_ram, sess_rom, locked_out;
    int         errors = 0;
    int         checks = 0;

    secure_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    secure_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .lock_req   (lock_req),
        .bus        (bus),
        .sess_ram   (sess_ram),
        .sess_rom   (sess_rom),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] k);
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_lock();
        lock_req = 1'b1;
        tick();
        lock_req = 1'b0;
    endtask

    task automatic access(input string tag, input logic we, input logic rom, input logic [3:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_d, input logic exp_e);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_rom   = rom;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
        check({tag, ".vld"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".data"}, 32'(bus.rsp_data), 32'(exp_d));
        check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_e));
        tick();
        check({tag, ".idle"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_in = 8'h00;
        lock_req = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_rom = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        tick();
        check("reset.status", {sess_ram, sess_rom, locked_out}, 32'd0);
        check("reset.ready", 32'(bus.req_ready), 32'd1);
        check("reset.rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
        rst = 1'b0;
        tick();

        // RAM session: write then read back
        send_key(8'hBF);
        check("ramkey.sess", {sess_ram, sess_rom, locked_out}, 32'b100);
        access("wr3", 1'b1, 1'b0, 4'd3, 8'hA5, 8'h00, 1'b0);
        access("rd3", 1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0);

        // Denied RAM write leaves old contents
        access("wr2", 1'b1, 1'b0, 4'd2, 8'h77, 8'h00, 1'b0);
        do_lock();
        check("lock.sess", 32'(sess_ram), 32'd0);
        access("wr2_denied", 1'b1, 1'b0, 4'd2, 8'h11, 8'h00, 1'b1);
        send_key(8'hBF);
        access("rd2_old", 1'b0, 1'b0, 4'd2, 8'h00, 8'h77, 1'b0);

        // Read then write same address on consecutive cycles
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_rom = 1'b0; bus.req_addr = 4'd3;
        tick();
        check("rw.rd_data", 32'(bus.rsp_data), 32'hA5);
        bus.req_we = 1'b1; bus.req_wdata = 8'hC3;
        tick();
        bus.req_valid = 1'b0;
        check("rw.wr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'h200);
        tick();
        access("rd3_new", 1'b0, 1'b0, 4'd3, 8'h00, 8'hC3, 1'b0);

        // ROM session and region permissions
        send_key(8'h3E);
        check("romkey.sess", {sess_ram, sess_rom, locked_out}, 32'b010);
        access("romwr0", 1'b1, 1'b1, 4'd0, 8'h5A, 8'h00, 1'b0);
        access("ramrd_in_rom", 1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 1'b1);
        do_lock();
        check("romlock.sess", 32'(sess_rom), 32'd0);
        access("romrd0", 1'b0, 1'b1, 4'd0, 8'h00, 8'h5A, 1'b0);
        access("romwr_denied", 1'b1, 1'b1, 4'd0, 8'h99, 8'h00, 1'b1);
        access("romrd0_again", 1'b0, 1'b1, 4'd0, 8'h00, 8'h5A, 1'b0);

        // lock_req wins over a same-cycle key
        lock_req = 1'b1;
        send_key(8'hBF);
        lock_req = 1'b0;
        check("lockprio.sess", 32'(sess_ram), 32'd0);

        // Three bad keys (lock_req in between keeps the count) -> lockout
        send_key(8'h00);
        send_key(8'h00);
        check("twobad.locked", 32'(locked_out), 32'd0);
        do_lock();
        send_key(8'h00);
        for (int i = 0; i < 16; i++) begin
            check("lockout.locked", 32'(locked_out), 32'd1);
            check("lockout.ready", 32'(bus.req_ready), 32'd0);
            key_valid = (i == 3);
            key_in    = 8'hBF;
            tick();
        end
        key_valid = 1'b0;
        check("afterlock.status", {sess_ram, sess_rom, locked_out}, 32'd0);
        check("afterlock.ready", 32'(bus.req_ready), 32'd1);
        send_key(8'hBF);
        check("afterlock.ramkey", 32'(sess_ram), 32'd1);

        // Reset mid-session with a response in flight
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_rom = 1'b0; bus.req_addr = 4'd3;
        tick();
        bus.req_valid = 1'b0;
        check("rstsess.pre", 32'(bus.rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstsess.status", {sess_ram, sess_rom, locked_out}, 32'd0);
        check("rstsess.rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
        rst = 1'b0;
        tick();

        // Reset mid-lockout
        send_key(8'h00);
        send_key(8'h00);
        send_key(8'h00);
        tick();
        tick();
        check("rstlock.pre", 32'(locked_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstlock.status", {sess_ram, sess_rom, locked_out}, 32'd0);
        check("rstlock.ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        tick();
        send_key(8'hBF);
        access("rd3_after_rst", 1'b0, 1'b0, 4'd3, 8'h00, 8'hC3, 1'b0);

        // Idle session behaviour
        send_key(8'hBF);
`ifdef SECURE_MEM_TIMEOUT_EN
        for (int i = 1; i < 32; i++) tick();
        check("timeout.before", 32'(sess_ram), 32'd1);
        tick();
        check("timeout.after", 32'(sess_ram), 32'd0);
        access("timeout.rd", 1'b0, 1'b0, 4'd3, 8'h00, 8'h00, 1'b1);
`else
        for (int i = 0; i < 40; i++) tick();
        check("persist.sess", 32'(sess_ram), 32'd1);
        access("persist.rd", 1'b0, 1'b0, 4'd3, 8'h00, 8'hC3, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/secure_mem_ctrl.md
SECURE_MEM_CTRL -- requirements
Module: secure_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; each region holds DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter KEY_W, default 8, key width.
REQ-004 SHALL have parameters RAM_KEY (default 8'hBF) and ROM_KEY (default 8'h3E), unlock keys, KEY_W bits each.
REQ-005 SHALL have parameter MAX_FAILS, default 3, consecutive bad keys that trigger lockout.
REQ-006 SHALL have parameter LOCK_CYCLES, default 16, lockout duration in clk cycles.
REQ-007 SHALL have parameter TIMEOUT, default 32, idle-session limit in cycles (used only under REQ-027).
REQ-008 SHALL have ports, in order: clk in 1, clock; rst in 1, reset (asynchronous, active-high).
REQ-009 SHALL have key_valid in 1 (key presented) and key_in in KEY_W (key value).
REQ-010 SHALL have lock_req in 1, ends the current session.
REQ-011 SHALL have req_valid in 1, req_ready out 1, req_we in 1, req_rom in 1 (1 = ROM region), req_addr in ADDR_W, req_wdata in DATA_W.
REQ-012 SHALL have rsp_valid out 1, rsp_data out DATA_W, rsp_err out 1 (access denied).
REQ-013 SHALL have status outputs sess_ram, sess_rom and locked_out, each out 1.

Function
REQ-014 SHALL implement states IDLE, SESS_RAM, SESS_ROM and LOCKOUT; sess_ram, sess_rom and locked_out SHALL equal the state decode.
REQ-015 SHALL, on key_valid outside LOCKOUT: if key_in == RAM_KEY, go to SESS_RAM; else if key_in == ROM_KEY, go to SESS_ROM; both SHALL clear fail_cnt.
REQ-016 SHALL, on a non-matching key, increment fail_cnt and go to IDLE; when fail_cnt reaches MAX_FAILS, go to LOCKOUT instead.
REQ-017 SHALL hold LOCKOUT exactly LOCK_CYCLES cycles, ignoring key_valid throughout, then enter IDLE with fail_cnt = 0.
REQ-018 SHALL give lock_req priority over key_valid in the same cycle; it SHALL return SESS_* to IDLE with fail_cnt unchanged.
REQ-019 SHALL drive req_ready = 0 in LOCKOUT and 1 otherwise; a request is accepted when req_valid && req_ready.
REQ-020 SHALL evaluate permissions for an accepted request against the state before any same-cycle key or lock event.
REQ-021 SHALL apply these permissions:
- ROM read: always allowed.
- RAM read or write: SESS_RAM only.
- ROM write: SESS_ROM only.
REQ-022 SHALL, for an allowed write, update the word at req_addr at the accepting edge.
REQ-023 SHALL assert rsp_valid for one cycle, exactly 1 cycle after each accepted request:
- Allowed read: rsp_data = stored word, rsp_err = 0.
- Allowed write: rsp_data = 0, rsp_err = 0.
- Denied access: rsp_data = 0, rsp_err = 1, memory unchanged.
REQ-024 SHALL return the old word for a read followed by a write to the same address on the next cycle (each response reflects memory at its own accept edge).
REQ-025 SHALL hold rsp_data = 0 and rsp_err = 0 whenever rsp_valid = 0.

Reset
REQ-026 SHALL, on rst asynchronously, force state IDLE, fail_cnt 0, lockout and timeout counters 0, rsp_valid/rsp_err/rsp_data 0 and req_ready 1; memory contents are not reset. A reset during LOCKOUT or a session SHALL abort it immediately.

Configuration
REQ-027 SHALL, when macro SECURE_MEM_TIMEOUT_EN is defined:
- Return any SESS_* state to IDLE after TIMEOUT consecutive cycles with no accepted request.
- Restart the idle counter on each accepted request or session entry.
Without the macro, sessions SHALL persist until lock_req, a bad key or reset, and no timeout counter SHALL be present.

Verification
REQ-028 SHALL cover: key_in = 8'hBF, then write addr 3 = 8'hA5, then read addr 3 -> rsp_valid 1 cycle after accept each time; read data 8'hA5, rsp_err 0.
REQ-029 SHALL cover: from IDLE, write RAM addr 2 = 8'h11 -> rsp_err 1; then key 8'hBF and read addr 2 -> old contents returned, not 8'h11.
REQ-030 SHALL cover: key 8'h3E, write ROM addr 0 = 8'h5A, lock_req, read ROM addr 0 -> 8'h5A, rsp_err 0; a later ROM write without a session -> rsp_err 1.
REQ-031 SHALL cover: three keys of 8'h00 -> locked_out = 1 and req_ready = 0 for exactly 16 cycles; key 8'hBF sent during LOCKOUT is ignored; afterwards key 8'hBF -> sess_ram = 1.
REQ-032 SHALL cover: rst asserted mid-LOCKOUT and mid-session -> IDLE and all outputs 0 immediately; earlier written RAM data still readable after re-unlock.
REQ-033 SHALL cover, with SECURE_MEM_TIMEOUT_EN: key 8'hBF then 32 idle cycles -> sess_ram falls; a following RAM read -> rsp_err 1.
